// File: rtl/dat_mem_arb.sv
// dat_mem_arb: round-robin two-port arbiter in front of a single-port data memory.
// Define DAT_MEM_ARB_CLEAR_EN to zero [CLR_BASE..2^AW-1] after reset before any grant.
module dat_mem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int CLR_BASE = 61
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_dat_out,
  output logic          busy
);
  logic          last_b_q, last_b_d;
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          clearing, serve, a_rd, b_rd;
`ifdef DAT_MEM_ARB_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  assign busy     = state_q == ST_CLEAR;
  assign clearing = busy & ~reset;
  always_comb begin
    state_d   = (clearing && clr_ptr_q == '1) ? ST_SERVE : state_q;
    clr_ptr_d = clearing ? clr_ptr_q + 1'b1 : clr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= AW'(CLR_BASE);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end
`else
  assign busy     = 1'b0;
  assign clearing = 1'b0;
`endif
  // last_b_q=1 means B was granted most recently, so A wins the next tie
  assign serve = ~reset & ~busy;
  assign a_gnt = serve & a_req & (~b_req | last_b_q);
  assign b_gnt = serve & b_req & ~a_gnt;
  assign a_rd  = a_gnt & ~a_we;
  assign b_rd  = b_gnt & ~b_we;
  always_comb begin
    last_b_d   = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
    mem_wr_en  = clearing | (a_gnt & a_we) | (b_gnt & b_we);
    mem_rd_en  = a_rd | b_rd;
    mem_dat_in = (a_gnt & a_we) ? a_wdata : (b_gnt & b_we) ? b_wdata : '0;
    mem_addr   = a_gnt ? a_addr : b_gnt ? b_addr : '0;
`ifdef DAT_MEM_ARB_CLEAR_EN
    mem_addr   = clearing ? clr_ptr_q : mem_addr;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      if (a_rd) a_rdata_q <= mem_dat_out;
      if (b_rd) b_rdata_q <= mem_dat_out;
    end
  end
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_dat_mem_arb.sv
// tb_dat_mem_arb: directed checks of arbitration, read latency, reset and optional clear.
module tb_dat_mem_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_en, mem_rd_en, busy;
  logic [7:0] a_rdata, b_rdata, mem_addr, mem_dat_in, mem_dat_out;
  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  assign mem_dat_out = mem[mem_addr];

  dat_mem_arb dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_dat_out(mem_dat_out), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_timeout busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b0;
    tick();
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_wr_en, mem_rd_en} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl gnt_a/b,wr,rd=%b want 0000", {a_gnt, b_gnt, mem_wr_en, mem_rd_en});
    end
    total++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 18'b0) begin
      bad++;
      $display("FAIL reset_rd rvalid=%b%b rdata=%h/%h want 0", a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0;
    reset = 1'b0;
    wait_idle();
  endtask

  task automatic test_first_tie;
    mem[8'h10] = 8'h11;
    mem[8'h20] = 8'h22;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_rd_en, mem_wr_en, mem_addr} !== {4'b1010, 8'h10}) begin
      bad++;
      $display("FAIL tie_c0 a,b,rd,wr=%b addr=%h want 1010 10", {a_gnt, b_gnt, mem_rd_en, mem_wr_en}, mem_addr);
    end
    tick();
    a_req = 1'b0;
    #1;
    total++;
    if ({a_gnt, b_gnt, a_rvalid, a_rdata, mem_addr} !== {3'b011, 8'h11, 8'h20}) begin
      bad++;
      $display("FAIL tie_c1 a,b,rv=%b rdata=%h addr=%h want 011 11 20", {a_gnt, b_gnt, a_rvalid}, a_rdata, mem_addr);
    end
    tick();
    b_req = 1'b0;
    #1;
    total++;
    if ({a_rvalid, b_rvalid, b_rdata, a_rdata} !== {2'b01, 8'h22, 8'h11}) begin
      bad++;
      $display("FAIL tie_c2 rv_a,b=%b b_rdata=%h a_rdata=%h want 01 22 11", {a_rvalid, b_rvalid}, b_rdata, a_rdata);
    end
    total++;
    if ({a_gnt, b_gnt, mem_rd_en, mem_wr_en, mem_addr, mem_dat_in} !== 20'b0) begin
      bad++;
      $display("FAIL idle_out ctrl=%b addr=%h din=%h want 0", {a_gnt, b_gnt, mem_rd_en, mem_wr_en}, mem_addr, mem_dat_in);
    end
  endtask

  task automatic test_alternate;
    logic [1:0] want;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    for (int i = 0; i < 6; i++) begin
      #1;
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      total++;
      if ({a_gnt, b_gnt} !== want) begin
        bad++;
        $display("FAIL alt_%0d gnt_a,b=%b want %b", i, {a_gnt, b_gnt}, want);
      end
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_write_read;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00;
    tick();
    a_addr = 8'h80;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h80; b_wdata = 8'h5A;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_dat_in} !== {4'b0110, 8'h80, 8'h5A}) begin
      bad++;
      $display("FAIL wr_first ctrl=%b addr=%h din=%h want 0110 80 5a", {a_gnt, b_gnt, mem_wr_en, mem_rd_en}, mem_addr, mem_dat_in);
    end
    tick();
    b_req = 1'b0;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_rd_en, a_rvalid} !== 4'b1010) begin
      bad++;
      $display("FAIL rd_second a,b,rd,rv=%b want 1010", {a_gnt, b_gnt, mem_rd_en, a_rvalid});
    end
    tick();
    a_req = 1'b0;
    #1;
    total++;
    if ({a_rvalid, a_rdata} !== {1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL rd_after_wr rvalid=%b rdata=%h want 1 5a", a_rvalid, a_rdata);
    end
    tick();
    total++;
    if ({a_rvalid, a_rdata} !== {1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL rdata_hold rvalid=%b rdata=%h want 0 5a", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_reset_midstream;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL pre_rst0 gnt_a,b=%b want 01", {a_gnt, b_gnt});
    end
    tick();
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL pre_rst1 gnt_a,b=%b want 10", {a_gnt, b_gnt});
    end
    tick();
    reset = 1'b1;
    a_we = 1'b1;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_wr_en, mem_rd_en} !== 4'b0) begin
      bad++;
      $display("FAIL mid_rst ctrl=%b want 0000", {a_gnt, b_gnt, mem_wr_en, mem_rd_en});
    end
    tick();
    total++;
    if ({a_rvalid, b_rvalid, a_rdata} !== 10'b0) begin
      bad++;
      $display("FAIL mid_rst_rd rv=%b rdata=%h want 00 00", {a_rvalid, b_rvalid}, a_rdata);
    end
    a_we = 1'b0;
    reset = 1'b0;
    wait_idle();
    #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL post_rst_tie gnt_a,b=%b want 10", {a_gnt, b_gnt});
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    tick();
  endtask

`ifdef DAT_MEM_ARB_CLEAR_EN
  task automatic test_clear;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({busy, mem_wr_en, mem_rd_en, mem_addr, mem_dat_in} !== {3'b110, 8'd61, 8'h00}) begin
      bad++;
      $display("FAIL clr_first busy,wr,rd=%b addr=%0d din=%h want 110 61 00", {busy, mem_wr_en, mem_rd_en}, mem_addr, mem_dat_in);
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n != 195) begin
      bad++;
      $display("FAIL clr_len cycles=%0d want 195", n);
    end
    total++;
    if ({mem[60], mem[61], mem[128], mem[255]} !== 32'hFF000000) begin
      bad++;
      $display("FAIL clr_mem m60=%h m61=%h m128=%h m255=%h want ff 00 00 00", mem[60], mem[61], mem[128], mem[255]);
    end
  endtask

  task automatic test_clear_restart;
    int n;
    int g;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    g = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (a_gnt !== 1'b0) g++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({busy, mem_addr} !== {1'b1, 8'd61}) begin
      bad++;
      $display("FAIL clr_restart busy=%b addr=%0d want 1 61", busy, mem_addr);
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (a_gnt !== 1'b0) g++;
      tick();
      n++;
    end
    total++;
    if (n != 195 || g != 0) begin
      bad++;
      $display("FAIL clr_stall cycles=%0d gnts=%0d want 195 0", n, g);
    end
    #1;
    total++;
    if (a_gnt !== 1'b1) begin
      bad++;
      $display("FAIL clr_release a_gnt=%b want 1", a_gnt);
    end
    tick();
    a_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_first_tie();
    test_alternate();
    test_write_read();
    test_reset_midstream();
`ifdef DAT_MEM_ARB_CLEAR_EN
    test_clear();
    test_clear_restart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
